// File: rtl/button_pkg.sv
// Shared types and defaults for the button debounce controller.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  localparam int DEF_TICK_DIV       = 907;
  localparam int DEF_STABLE_SAMPLES = 44;
  localparam int DEF_HOLD_SAMPLES   = 22050;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One debounced button: 2-flop synchroniser, debounce FSM, edge pulses,
// toggle latch and long-press counter.
module button_channel
  import button_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int HOLD_SAMPLES   = DEF_HOLD_SAMPLES
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic sample_tick,
  input  logic clr_toggle,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_toggle,
  output logic btn_hold
);

  localparam int SW = cnt_w(STABLE_SAMPLES);
  localparam int HW = cnt_w(HOLD_SAMPLES + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_SAMPLES);

  logic          sync_p0;
  logic          sync_p1;
  btn_state_e    state;
  logic [SW-1:0] stable_cnt;
  logic [HW-1:0] hold_cnt;
  logic          press_r;
  logic          release_r;
  logic          toggle_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      state      <= RELEASED;
      stable_cnt <= '0;
      hold_cnt   <= '0;
      press_r    <= 1'b0;
      release_r  <= 1'b0;
      toggle_r   <= 1'b0;
    end else begin
      // synchroniser stage: runs even while disabled
      sync_p0   <= btn_raw;
      sync_p1   <= sync_p0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      if (clr_toggle)
        toggle_r <= 1'b0;
      else if (press_r && enable)
        toggle_r <= ~toggle_r;
      // debounce stage: advances once per sample tick
      if (sample_tick) begin
        unique case (state)
          RELEASED: begin
            if (sync_p1) begin
              if (STABLE_SAMPLES == 1) begin
                state   <= PRESSED;
                press_r <= 1'b1;
              end else begin
                state      <= PRESS_PEND;
                stable_cnt <= SW'(1);
              end
            end
          end
          PRESS_PEND: begin
            if (!sync_p1) begin
              state <= RELEASED;
            end else if (stable_cnt == STABLE_LAST) begin
              state    <= PRESSED;
              press_r  <= 1'b1;
              hold_cnt <= '0;
            end else begin
              stable_cnt <= stable_cnt + SW'(1);
            end
          end
          PRESSED: begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
            if (!sync_p1) begin
              if (STABLE_SAMPLES == 1) begin
                state     <= RELEASED;
                release_r <= 1'b1;
                hold_cnt  <= '0;
              end else begin
                state      <= RELEASE_PEND;
                stable_cnt <= SW'(1);
              end
            end
          end
          RELEASE_PEND: begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
            if (sync_p1) begin
              state <= PRESSED;
            end else if (stable_cnt == STABLE_LAST) begin
              state     <= RELEASED;
              release_r <= 1'b1;
              hold_cnt  <= '0;
            end else begin
              stable_cnt <= stable_cnt + SW'(1);
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

  assign btn_level   = (state == PRESSED) || (state == RELEASE_PEND);
  assign btn_press   = press_r & enable;
  assign btn_release = release_r & enable;
  assign btn_toggle  = toggle_r;
  assign btn_hold    = (hold_cnt == HOLD_MAX);

endmodule

// File: rtl/button_debounce_ctrl.sv
// Multi-channel button debouncer: shared sample-tick divider feeding one
// button_channel per input pin.
module button_debounce_ctrl
  import button_pkg::*;
#(
  parameter int NUM_BTN        = 5,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int HOLD_SAMPLES   = DEF_HOLD_SAMPLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clr_toggle,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic               sample_tick,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_toggle,
  output logic [NUM_BTN-1:0] btn_hold
);

  localparam int TW = cnt_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      tick_cnt <= '0;
    else if (enable)
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
  end

  // Gated by reset too so a TICK_DIV=1 divider stays silent while held in reset.
  assign sample_tick = enable && reset && (tick_cnt == TICK_LAST);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .HOLD_SAMPLES   (HOLD_SAMPLES)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .sample_tick (sample_tick),
      .clr_toggle  (clr_toggle),
      .btn_raw     (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_toggle  (btn_toggle[i]),
      .btn_hold    (btn_hold[i])
    );
  end

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Bench for button_debounce_ctrl: directed table, corner sequences and a
// randomized run against a run-length reference model.
module tb_button_debounce_ctrl;

  localparam int NB = 5;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int HD = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic          clr_toggle = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic          sample_tick;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_toggle, btn_hold;

  int total = 0;
  int bad   = 0;

  button_debounce_ctrl #(
    .NUM_BTN(NB), .TICK_DIV(TD), .STABLE_SAMPLES(ST), .HOLD_SAMPLES(HD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clr_toggle  (clr_toggle),
    .btn_in      (btn_in),
    .sample_tick (sample_tick),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_toggle  (btn_toggle),
    .btn_hold    (btn_hold)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NB-1:0] btn;
    int            cycles;
    logic [NB-1:0] level;
    logic [NB-1:0] press_seen;
    logic [NB-1:0] tog;
  } vec_t;

  vec_t tbl[7];

  // reference model state
  int            m_en_cnt;
  logic [NB-1:0] m_s1, m_s2, m_level, m_pr, m_rr, m_tog;
  int            m_run[NB];
  int            m_hold[NB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    enable     = 1'b1;
    clr_toggle = 1'b0;
    btn_in     = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_for(input bit rel, input int ch, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if ((rel ? btn_release[ch] : btn_press[ch]) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic model_reset();
    m_en_cnt = 0;
    m_s1 = '0; m_s2 = '0; m_level = '0; m_pr = '0; m_rr = '0; m_tog = '0;
    for (int i = 0; i < NB; i++) begin
      m_run[i]  = 0;
      m_hold[i] = 0;
    end
  endtask

  // Debounced level flips after ST consecutive samples that disagree with it.
  task automatic model_edge(input logic [NB-1:0] b, input logic e, input logic c);
    logic          tick;
    logic [NB-1:0] npr, nrr;
    tick = e && ((m_en_cnt % TD) == TD - 1);
    if (c) m_tog = '0;
    else if (e) m_tog = m_tog ^ m_pr;
    npr = '0;
    nrr = '0;
    if (tick) begin
      for (int i = 0; i < NB; i++) begin
        if (m_level[i]) m_hold[i] = (m_hold[i] < HD) ? m_hold[i] + 1 : HD;
        if (m_s2[i] != m_level[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == ST) begin
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
          m_hold[i]  = 0;
          if (m_level[i]) npr[i] = 1'b1;
          else nrr[i] = 1'b1;
        end
      end
    end
    m_pr = npr;
    m_rr = nrr;
    m_s2 = m_s1;
    m_s1 = b;
    if (e) m_en_cnt++;
  endtask

  initial begin
    int            n;
    logic [NB-1:0] seen;
    logic          tseen;
    logic [NB-1:0] rb;
    logic [NB-1:0] exp_hold;

    do_reset();
    chk("rst_level", btn_level, 0);
    chk("rst_toggle", btn_toggle, 0);
    chk("rst_hold", btn_hold, 0);
    chk("rst_tick", sample_tick, 0);

    // press/ glitch table: ch0 held, ch1 short glitch, then ch1 full press
    tbl[0] = '{5'b00001, 11, 5'b00000, 5'b00000, 5'b00000};
    tbl[1] = '{5'b00001,  1, 5'b00001, 5'b00001, 5'b00000};
    tbl[2] = '{5'b00001,  1, 5'b00001, 5'b00000, 5'b00001};
    tbl[3] = '{5'b00011,  8, 5'b00001, 5'b00000, 5'b00001};
    tbl[4] = '{5'b00001,  8, 5'b00001, 5'b00000, 5'b00001};
    tbl[5] = '{5'b00011, 10, 5'b00001, 5'b00000, 5'b00001};
    tbl[6] = '{5'b00011,  1, 5'b00011, 5'b00010, 5'b00001};
    for (int r = 0; r < 7; r++) begin
      btn_in = tbl[r].btn;
      seen   = '0;
      for (int k = 0; k < tbl[r].cycles; k++) begin
        step();
        seen |= btn_press;
      end
      chk($sformatf("tbl%0d_level", r), btn_level, tbl[r].level);
      chk($sformatf("tbl%0d_press", r), seen, tbl[r].press_seen);
      chk($sformatf("tbl%0d_toggle", r), btn_toggle, tbl[r].tog);
    end

    // long press on ch2
    do_reset();
    btn_in = 5'b00100;
    wait_for(1'b0, 2, 40, n);
    chk("hold_press_lat", n, 12);
    repeat (19) step();
    chk("hold_early", btn_hold[2], 1'b0);
    step();
    chk("hold_set", btn_hold[2], 1'b1);
    chk("hold_level", btn_level[2], 1'b1);
    btn_in = '0;
    wait_for(1'b1, 2, 40, n);
    chk("hold_rel_lat", n, 12);
    chk("hold_clear", btn_hold[2], 1'b0);
    chk("hold_rel_level", btn_level[2], 1'b0);
    step();
    chk("rel_one_cycle", btn_release[2], 1'b0);

    // clr_toggle against a coincident press
    do_reset();
    btn_in = 5'b10000;
    wait_for(1'b0, 4, 40, n);
    chk("tog4_press", n, 12);
    step();
    chk("tog4_set", btn_toggle, 5'b10000);
    btn_in = 5'b11000;
    wait_for(1'b0, 3, 40, n);
    chk("tog3_press_seen", n > 0, 1'b1);
    clr_toggle = 1'b1;
    step();
    clr_toggle = 1'b0;
    chk("tog_clr_wins", btn_toggle, 5'b00000);
    step();
    chk("tog_clr_stays", btn_toggle, 5'b00000);

    // asynchronous reset during PRESS_PEND
    do_reset();
    btn_in = 5'b10000;
    repeat (35) step();
    chk("pre_rst_state", {btn_level[4], btn_toggle[4], btn_hold[4]}, 3'b111);
    btn_in = 5'b10001;
    repeat (6) step();
    #2 reset = 1'b0;
    #1;
    chk("arst_level", btn_level, 0);
    chk("arst_toggle", btn_toggle, 0);
    chk("arst_hold", btn_hold, 0);
    chk("arst_pulses", {btn_press, btn_release, sample_tick}, 0);
    btn_in = 5'b00001;
    @(posedge clock);
    #1 reset = 1'b1;
    wait_for(1'b0, 0, 40, n);
    chk("post_rst_press_lat", n, 12);

    // enable freeze of the tick counter
    do_reset();
    step();
    step();
    chk("tick_cnt2", sample_tick, 1'b0);
    step();
    chk("tick_cnt3", sample_tick, 1'b1);
    enable = 1'b0;
    #1;
    chk("tick_forced_off", sample_tick, 1'b0);
    tseen = 1'b0;
    repeat (21) begin
      step();
      tseen |= sample_tick;
    end
    chk("tick_absent_dis", tseen, 1'b0);
    enable = 1'b1;
    #1;
    chk("tick_resume", sample_tick, 1'b1);
    step();
    chk("tick_wrap", sample_tick, 1'b0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    rb = '0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 6 * (i + 1)) == 0) rb[i] = ~rb[i];
      btn_in     = rb;
      enable     = ($urandom_range(0, 9) != 0);
      clr_toggle = ($urandom_range(0, 29) == 0);
      @(posedge clock);
      model_edge(rb, enable, clr_toggle);
      #1;
      for (int i = 0; i < NB; i++) exp_hold[i] = (m_hold[i] == HD);
      chk("rnd_tick", sample_tick, enable && ((m_en_cnt % TD) == TD - 1));
      chk("rnd_level", btn_level, m_level);
      chk("rnd_press", btn_press, m_pr & {NB{enable}});
      chk("rnd_release", btn_release, m_rr & {NB{enable}});
      chk("rnd_toggle", btn_toggle, m_tog);
      chk("rnd_hold", btn_hold, exp_hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
